// File: rtl/lvds_video_decoder.sv
// LVDS receive-side video decoder: unpacks deserialized 21-bit words into RGB666 plus syncs,
// measures line/frame timing, tracks pixel position and reports lock to a stable format.
module lvds_video_decoder #(
    parameter int CNT_W       = 12,
    parameter int LOCK_FRAMES = 3,
    parameter int TIMEOUT     = 2**22
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [20:0]      datain,
    output logic [5:0]       red,
    output logic [5:0]       green,
    output logic [5:0]       blue,
    output logic             de_out,
    output logic             hsync_out,
    output logic             vsync_out,
    output logic [CNT_W-1:0] pix_x,
    output logic [CNT_W-1:0] pix_y,
    output logic [CNT_W-1:0] h_total,
    output logic [CNT_W-1:0] h_active,
    output logic [CNT_W-1:0] v_active,
    output logic [CNT_W-1:0] v_total,
    output logic             locked,
    output logic             format_err
);
    localparam int TO_W = $clog2(TIMEOUT) + 1;
    localparam int MW   = $clog2(LOCK_FRAMES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT - 1);
    localparam logic [MW-1:0]    LOCK_LAST = MW'(LOCK_FRAMES - 1);

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    logic [5:0]       red_s, green_s, blue_s;
    logic             hs_s, vs_s, de_s;
    logic             de_d_r, hs_d_r, vs_d_r;
    logic             hs_fall_s, vs_fall_s, de_rise_s, de_fall_s;
    logic [CNT_W-1:0] hs_cnt_r, de_cnt_r, v_tot_cnt_r, v_act_cnt_r;
    logic [CNT_W-1:0] line_ref_r, act_ref_r;
    logic             have_line_r, have_act_r, line_err_r;
    logic [CNT_W-1:0] snap_ht_s, snap_ha_s, snap_va_s, snap_vt_s;
    logic             line_mis_s, act_mis_s, sat_s, frame_err_s, snap_eq_s;
    state_t           state_r;
    logic [MW-1:0]    match_cnt_r;
    logic             have_prev_r;
    logic [TO_W-1:0]  to_cnt_r;

    // Bit unpacking of the deserialized word into colour and timing fields.
    always_comb begin
        red_s   = {datain[1], datain[2], datain[3], datain[4], datain[5], datain[6]};
        green_s = {datain[9], datain[10], datain[11], datain[12], datain[13], datain[0]};
        blue_s  = {datain[17], datain[18], datain[19], datain[20], datain[7], datain[8]};
        hs_s    = datain[16];
        vs_s    = datain[15];
        de_s    = datain[14];
    end

    assign hs_fall_s = hs_d_r & ~hsync_out;
    assign vs_fall_s = vs_d_r & ~vsync_out;
    assign de_rise_s = de_out & ~de_d_r;
    assign de_fall_s = de_d_r & ~de_out;

    // Current-clock line events folded into the frame accumulators (line handled before frame end).
    assign line_mis_s  = hs_fall_s & have_line_r & (hs_cnt_r != line_ref_r);
    assign act_mis_s   = de_fall_s & have_act_r & (de_cnt_r != act_ref_r);
    assign sat_s       = (hs_cnt_r == CNT_MAX) | (de_cnt_r == CNT_MAX)
                       | (hs_fall_s & (v_tot_cnt_r == CNT_MAX))
                       | (de_fall_s & (v_act_cnt_r == CNT_MAX));
    assign frame_err_s = line_err_r | line_mis_s | act_mis_s | sat_s;
    assign snap_ht_s   = (hs_fall_s & ~have_line_r) ? hs_cnt_r : line_ref_r;
    assign snap_ha_s   = (de_fall_s & ~have_act_r) ? de_cnt_r : act_ref_r;
    assign snap_vt_s   = hs_fall_s ? sat_inc(v_tot_cnt_r) : v_tot_cnt_r;
    assign snap_va_s   = de_fall_s ? sat_inc(v_act_cnt_r) : v_act_cnt_r;
    assign snap_eq_s   = ({snap_ht_s, snap_ha_s, snap_va_s, snap_vt_s}
                          == {h_total, h_active, v_active, v_total});

    // Unpack register stage; pix_x is driven from the incoming DE so it lines up with de_out.
    always_ff @(posedge clk) begin
        if (rst) begin
            red       <= 6'd0;
            green     <= 6'd0;
            blue      <= 6'd0;
            de_out    <= 1'b0;
            hsync_out <= 1'b1;
            vsync_out <= 1'b1;
            de_d_r    <= 1'b0;
            hs_d_r    <= 1'b1;
            vs_d_r    <= 1'b1;
            pix_x     <= '0;
        end else begin
            red       <= red_s;
            green     <= green_s;
            blue      <= blue_s;
            de_out    <= de_s;
            hsync_out <= hs_s;
            vsync_out <= vs_s;
            de_d_r    <= de_out;
            hs_d_r    <= hsync_out;
            vs_d_r    <= vsync_out;
            if (de_s && !de_out) begin
                pix_x <= '0;
            end else if (de_s) begin
                pix_x <= sat_inc(pix_x);
            end
        end
    end

    // Line/frame measurement counters, cleared at every frame end.
    always_ff @(posedge clk) begin
        if (rst) begin
            hs_cnt_r    <= '0;
            de_cnt_r    <= '0;
            v_tot_cnt_r <= '0;
            v_act_cnt_r <= '0;
            line_ref_r  <= '0;
            act_ref_r   <= '0;
            have_line_r <= 1'b0;
            have_act_r  <= 1'b0;
            line_err_r  <= 1'b0;
            pix_y       <= '0;
        end else begin
            hs_cnt_r <= hs_fall_s ? CNT_ONE : sat_inc(hs_cnt_r);
            de_cnt_r <= de_rise_s ? CNT_ONE : (de_out ? sat_inc(de_cnt_r) : de_cnt_r);
            if (vs_fall_s) begin
                v_tot_cnt_r <= '0;
                v_act_cnt_r <= '0;
                line_ref_r  <= '0;
                act_ref_r   <= '0;
                have_line_r <= 1'b0;
                have_act_r  <= 1'b0;
                line_err_r  <= 1'b0;
                pix_y       <= '0;
            end else begin
                v_tot_cnt_r <= snap_vt_s;
                v_act_cnt_r <= snap_va_s;
                line_ref_r  <= snap_ht_s;
                act_ref_r   <= snap_ha_s;
                have_line_r <= have_line_r | hs_fall_s;
                have_act_r  <= have_act_r | de_fall_s;
                line_err_r  <= frame_err_s;
                if (de_fall_s) begin
                    pix_y <= sat_inc(pix_y);
                end
            end
        end
    end

    // Publish the snapshot of each measured frame; the published set is also the compare reference.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_total  <= '0;
            h_active <= '0;
            v_active <= '0;
            v_total  <= '0;
        end else if (vs_fall_s && state_r != ST_SEARCH) begin
            h_total  <= snap_ht_s;
            h_active <= snap_ha_s;
            v_active <= snap_va_s;
            v_total  <= snap_vt_s;
        end
    end

    // Lock FSM with frame-end matching and the VSync watchdog.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_SEARCH;
            match_cnt_r <= '0;
            have_prev_r <= 1'b0;
            to_cnt_r    <= '0;
            locked      <= 1'b0;
            format_err  <= 1'b0;
        end else begin
            format_err <= 1'b0;
            if (vs_fall_s) begin
                to_cnt_r <= '0;
                case (state_r)
                    ST_SEARCH: begin
                        state_r     <= ST_MEASURE;
                        match_cnt_r <= '0;
                        have_prev_r <= 1'b0;
                    end
                    ST_MEASURE: begin
                        // A frame carrying line errors is never kept as a reference.
                        have_prev_r <= ~frame_err_s;
                        if (have_prev_r && snap_eq_s && !frame_err_s) begin
                            match_cnt_r <= match_cnt_r + MW'(1);
                            if (match_cnt_r == LOCK_LAST) begin
                                state_r <= ST_LOCKED;
                                locked  <= 1'b1;
                            end
                        end else begin
                            match_cnt_r <= '0;
                        end
                    end
                    ST_LOCKED: begin
                        have_prev_r <= ~frame_err_s;
                        if (!snap_eq_s || frame_err_s) begin
                            state_r     <= ST_MEASURE;
                            match_cnt_r <= '0;
                            locked      <= 1'b0;
                            format_err  <= 1'b1;
                        end
                    end
                    default: begin
                        state_r     <= ST_SEARCH;
                        match_cnt_r <= '0;
                        have_prev_r <= 1'b0;
                        locked      <= 1'b0;
                    end
                endcase
            end else if (to_cnt_r == TO_LAST) begin
                to_cnt_r    <= '0;
                state_r     <= ST_SEARCH;
                match_cnt_r <= '0;
                have_prev_r <= 1'b0;
                locked      <= 1'b0;
                format_err  <= (state_r == ST_LOCKED);
            end else begin
                to_cnt_r <= to_cnt_r + TO_W'(1);
            end
        end
    end
endmodule
